// File: rtl/puf_controller_pkg.sv
// Shared constants for the arbiter-PUF sequencer: parameter defaults,
// FSM state encodings and small elaboration-time helpers.
package puf_controller_pkg;

  localparam int unsigned C_LENGTH_DEF      = 64;
  localparam int unsigned C_REPEATS_DEF     = 7;
  localparam int unsigned C_SETTLE_DEF      = 8;
  localparam int unsigned C_PULSE_WIDTH_DEF = 4;

  // Cycles the pulse stays high after FIRE so the 2-flop synchroniser catches the race result
  localparam int unsigned SAMPLE_CYCLES = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_FIRE   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_RELAX  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/puf_controller_if.sv
// Host-side request/response handshake of the PUF sequencer.
interface puf_controller_if #(
  parameter int unsigned C_LENGTH  = 64,
  parameter int unsigned C_REPEATS = 7
) ();

  localparam int unsigned ONES_W = $clog2(C_REPEATS + 1);

  logic                ireq_valid;
  logic [C_LENGTH-1:0] ireq_challenge;
  logic                oreq_ready;
  logic                oresp_valid;
  logic                iresp_ready;
  logic                oresp_bit;
  logic [ONES_W-1:0]   oresp_ones;
  logic                oresp_stable;

  modport master (
    output ireq_valid, ireq_challenge, iresp_ready,
    input  oreq_ready, oresp_valid, oresp_bit, oresp_ones, oresp_stable
  );

  modport slave (
    input  ireq_valid, ireq_challenge, iresp_ready,
    output oreq_ready, oresp_valid, oresp_bit, oresp_ones, oresp_stable
  );

endinterface

// File: rtl/puf_controller_sync_2ff.sv
// Two-flop synchroniser for the asynchronous arbiter response; resets to 0.
module sync_2ff (
  input  logic iclk,
  input  logic irst_n,
  input  logic id,
  output logic oq
);

  logic meta;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      meta <= 1'b0;
      oq   <= 1'b0;
    end else begin
      meta <= id;
      oq   <= meta;
    end
  end

endmodule

// File: rtl/puf_controller.sv
// Arbiter-PUF sequencer: loads a challenge, fires C_REPEATS race pulses with
// settle gaps, counts synchronised responses and returns a majority vote.
module puf_controller
  import puf_controller_pkg::*;
#(
  parameter int unsigned C_LENGTH      = C_LENGTH_DEF,
  parameter int unsigned C_REPEATS     = C_REPEATS_DEF,
  parameter int unsigned C_SETTLE      = C_SETTLE_DEF,
  parameter int unsigned C_PULSE_WIDTH = C_PULSE_WIDTH_DEF
) (
  input  logic                iclk,
  input  logic                irst_n,
  puf_controller_if.slave     host,
  output logic                opuf_pulse,
  output logic [C_LENGTH-1:0] opuf_challenge,
  input  logic                ipuf_response
);

  localparam int unsigned ONES_W  = $clog2(C_REPEATS + 1);
  localparam int unsigned CNT_MAX = max_u(max_u(C_SETTLE, C_PULSE_WIDTH), SAMPLE_CYCLES);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(C_SETTLE - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(C_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [ONES_W-1:0] REPEATS_N   = ONES_W'(C_REPEATS);
  localparam logic [ONES_W-1:0] HALF_N      = ONES_W'(C_REPEATS / 2);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ONES_W-1:0] ones;
  logic [ONES_W-1:0] reps;
  logic              resp_sync;

  sync_2ff u_sync (
    .iclk   (iclk),
    .irst_n (irst_n),
    .id     (ipuf_response),
    .oq     (resp_sync)
  );

  assign host.oreq_ready = (state == ST_IDLE);

  // The pulse is a register set on entry to FIRE and cleared on leaving SAMPLE,
  // so it is glitch-free and high for exactly C_PULSE_WIDTH + SAMPLE_CYCLES cycles.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      ones              <= '0;
      reps              <= '0;
      opuf_pulse        <= 1'b0;
      opuf_challenge    <= '0;
      host.oresp_valid  <= 1'b0;
      host.oresp_bit    <= 1'b0;
      host.oresp_ones   <= '0;
      host.oresp_stable <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.ireq_valid && host.oreq_ready) begin
            opuf_challenge <= host.ireq_challenge;
            ones           <= '0;
            reps           <= '0;
            cnt            <= '0;
            state          <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (cnt == SETTLE_LAST) begin
            cnt        <= '0;
            opuf_pulse <= 1'b1;
            state      <= ST_FIRE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_FIRE: begin
          if (cnt == PULSE_LAST) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            cnt        <= '0;
            ones       <= ones + ONES_W'(resp_sync);
            reps       <= reps + ONES_W'(1);
            opuf_pulse <= 1'b0;
            state      <= ST_RELAX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RELAX: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (reps == REPEATS_N) begin
              host.oresp_valid  <= 1'b1;
              host.oresp_bit    <= (ones > HALF_N);
              host.oresp_ones   <= ones;
              host.oresp_stable <= (ones == '0) || (ones == REPEATS_N);
              state             <= ST_DONE;
            end else begin
              opuf_pulse <= 1'b1;
              state      <= ST_FIRE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (host.iresp_ready) begin
            host.oresp_valid <= 1'b0;
            state            <= ST_IDLE;
          end
        end

        default: begin
          opuf_pulse       <= 1'b0;
          host.oresp_valid <= 1'b0;
          cnt              <= '0;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_controller.sv
// Directed bench for puf_controller with a scripted behavioural arbiter PUF.
module tb_puf_controller;

  localparam int unsigned C_LENGTH      = 64;
  localparam int unsigned C_REPEATS     = 7;
  localparam int unsigned C_SETTLE      = 8;
  localparam int unsigned C_PULSE_WIDTH = 4;
  localparam int unsigned LATENCY       = C_SETTLE + C_REPEATS * (C_PULSE_WIDTH + 2 + C_SETTLE);

  logic                iclk = 1'b0;
  logic                irst_n = 1'b0;
  logic                opuf_pulse;
  logic [C_LENGTH-1:0] opuf_challenge;
  logic                ipuf_response;

  puf_controller_if #(.C_LENGTH(C_LENGTH), .C_REPEATS(C_REPEATS)) host ();

  puf_controller #(
    .C_LENGTH      (C_LENGTH),
    .C_REPEATS     (C_REPEATS),
    .C_SETTLE      (C_SETTLE),
    .C_PULSE_WIDTH (C_PULSE_WIDTH)
  ) dut (
    .iclk           (iclk),
    .irst_n         (irst_n),
    .host           (host),
    .opuf_pulse     (opuf_pulse),
    .opuf_challenge (opuf_challenge),
    .ipuf_response  (ipuf_response)
  );

  always #5 iclk = ~iclk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural PUF: race n returns script[n] while the pulse is high
  logic [6:0]  script = '0;
  int unsigned race_idx = 0;
  logic [2:0]  race_sel;

  assign race_sel      = race_idx[2:0];
  assign ipuf_response = opuf_pulse && (race_idx < C_REPEATS) && script[race_sel];

  always @(negedge opuf_pulse) race_idx = race_idx + 1;

  // Pulse shape monitor: high run exactly PW+2, low run before each rise >= SETTLE
  bit          mon_en = 1'b1;
  bit          prev_pulse = 1'b0;
  int unsigned hi_run = 0;
  int unsigned lo_run = 100;

  always @(negedge iclk) begin
    if (mon_en) begin
      if (opuf_pulse && !prev_pulse) begin
        check_eq("pulse_low_gap", 64'(lo_run >= C_SETTLE), 64'd1);
        hi_run = 1;
      end else if (opuf_pulse) begin
        hi_run++;
      end else if (prev_pulse) begin
        check_eq("pulse_high_len", 64'(hi_run), 64'(C_PULSE_WIDTH + 2));
        lo_run = 1;
      end else begin
        lo_run++;
      end
      prev_pulse = opuf_pulse;
    end
  end

  task automatic send(input logic [63:0] ch);
    @(negedge iclk);
    host.ireq_valid     = 1'b1;
    host.ireq_challenge = ch;
    @(posedge iclk);
    #1;
    host.ireq_valid = 1'b0;
    check_eq("accept_ready_low", 64'(host.oreq_ready), 64'd0);
    check_eq("challenge_loaded", opuf_challenge, ch);
  endtask

  task automatic run_req(input logic [63:0] ch, input logic [6:0] scr,
                         input logic exp_bit, input logic [2:0] exp_ones, input logic exp_stable);
    int unsigned cycles;
    race_idx = 0;
    script   = scr;
    send(ch);
    cycles = 0;
    while (cycles < 300) begin
      @(posedge iclk);
      cycles++;
      #1;
      host.ireq_challenge = {$urandom, $urandom};
      if (host.oresp_valid) break;
    end
    check_eq("latency", 64'(cycles), 64'(LATENCY));
    @(negedge iclk);
    check_eq("resp_valid", 64'(host.oresp_valid), 64'd1);
    check_eq("resp_bit", 64'(host.oresp_bit), 64'(exp_bit));
    check_eq("resp_ones", 64'(host.oresp_ones), 64'(exp_ones));
    check_eq("resp_stable", 64'(host.oresp_stable), 64'(exp_stable));
    check_eq("challenge_hold", opuf_challenge, ch);
    check_eq("race_count", 64'(race_idx), 64'(C_REPEATS));
    check_eq("ready_busy", 64'(host.oreq_ready), 64'd0);
  endtask

  task automatic consume();
    @(negedge iclk);
    host.iresp_ready = 1'b1;
    @(posedge iclk);
    #1;
    host.iresp_ready = 1'b0;
    check_eq("consume_valid_low", 64'(host.oresp_valid), 64'd0);
    check_eq("consume_ready_high", 64'(host.oreq_ready), 64'd1);
  endtask

  initial begin
    int unsigned seen;
    int unsigned waited;
    logic [63:0] ch;

    host.ireq_valid     = 1'b0;
    host.ireq_challenge = '0;
    host.iresp_ready    = 1'b0;
    irst_n              = 1'b0;

    repeat (3) @(negedge iclk);
    check_eq("rst_pulse", 64'(opuf_pulse), 64'd0);
    check_eq("rst_challenge", opuf_challenge, 64'd0);
    check_eq("rst_valid", 64'(host.oresp_valid), 64'd0);
    check_eq("rst_ready", 64'(host.oreq_ready), 64'd1);
    check_eq("rst_ones", 64'(host.oresp_ones), 64'd0);
    check_eq("rst_bit", 64'(host.oresp_bit), 64'd0);
    check_eq("rst_stable", 64'(host.oresp_stable), 64'd0);
    irst_n = 1'b1;

    // Clean, alternating-minority and bare-majority responses
    run_req(64'hA5A5_A5A5_A5A5_A5A5, 7'b111_1111, 1'b1, 3'd7, 1'b1);
    consume();
    run_req(64'h0123_4567_89AB_CDEF, 7'b010_1010, 1'b0, 3'd3, 1'b0);
    consume();
    run_req(64'hDEAD_BEEF_CAFE_F00D, 7'b000_1111, 1'b1, 3'd4, 1'b0);
    consume();

    // Backpressure in DONE with all-zero responses
    ch = 64'h5A5A_0F0F_3C3C_9999;
    run_req(ch, 7'b000_0000, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge iclk);
      host.ireq_valid     = i[0];
      host.ireq_challenge = {$urandom, $urandom};
      check_eq("bp_valid", 64'(host.oresp_valid), 64'd1);
      check_eq("bp_ready", 64'(host.oreq_ready), 64'd0);
      check_eq("bp_bit", 64'(host.oresp_bit), 64'd0);
      check_eq("bp_ones", 64'(host.oresp_ones), 64'd0);
      check_eq("bp_stable", 64'(host.oresp_stable), 64'd1);
      check_eq("bp_challenge", opuf_challenge, ch);
    end
    @(negedge iclk);
    host.ireq_valid  = 1'b0;
    host.iresp_ready = 1'b1;
    @(posedge iclk);
    #1;
    host.iresp_ready = 1'b0;
    check_eq("bp_release_ready", 64'(host.oreq_ready), 64'd1);
    check_eq("bp_release_valid", 64'(host.oresp_valid), 64'd0);
    run_req(64'h1111_2222_3333_4444, 7'b111_1110, 1'b1, 3'd6, 1'b0);
    consume();

    // Reset while the pulse is high
    race_idx = 0;
    script   = 7'b111_1111;
    send(64'hFEED_FACE_0BAD_BEEF);
    waited = 0;
    while (!opuf_pulse && waited < 50) begin
      @(negedge iclk);
      waited++;
    end
    check_eq("midrst_pulse_seen", 64'(opuf_pulse), 64'd1);
    @(posedge iclk);
    #2;
    mon_en = 1'b0;
    irst_n = 1'b0;
    #1;
    check_eq("midrst_pulse_drop", 64'(opuf_pulse), 64'd0);
    check_eq("midrst_ready", 64'(host.oreq_ready), 64'd1);
    check_eq("midrst_challenge", opuf_challenge, 64'd0);
    @(negedge iclk);
    irst_n = 1'b1;
    seen = 0;
    repeat (150) begin
      @(negedge iclk);
      if (host.oresp_valid) seen++;
    end
    check_eq("midrst_no_valid", 64'(seen), 64'd0);
    check_eq("midrst_idle_ready", 64'(host.oreq_ready), 64'd1);
    prev_pulse = 1'b0;
    lo_run     = 100;
    mon_en     = 1'b1;
    run_req(64'h0F0F_F0F0_AAAA_5555, 7'b101_1101, 1'b1, 3'd5, 1'b0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/puf_controller.md
# puf_controller

Sequencer for the arbiter PUF. Accepts a challenge over a valid/ready handshake, applies it to the delay line, and fires C_REPEATS race pulses with settle gaps. Each asynchronous arbiter response is synchronised and counted, and the block returns a majority-voted response bit plus a stability flag. It sits between the host/test logic and `arbiter_puf`; the PUF instance itself stays outside this block.

## Interface
Parameters:
- C_LENGTH, 64 (from `parameters.vh`): challenge width.
- C_REPEATS, 7: race repetitions per challenge; odd, ≥1.
- C_SETTLE, 8: clock cycles with pulse low after a challenge load and after each race; ≥1.
- C_PULSE_WIDTH, 4: clock cycles pulse is high before sampling starts; ≥1.

Ports:
- iclk  in  1  system clock.
- irst_n  in  1  reset; asynchronous, active-low.
- ireq_valid  in  1  challenge request valid.
- ireq_challenge  in  C_LENGTH  challenge.
- oreq_ready  out  1  request accepted when high with ireq_valid.
- oresp_valid  out  1  result valid.
- iresp_ready  in  1  result consumed when high with oresp_valid.
- oresp_bit  out  1  majority response.
- oresp_ones  out  $clog2(C_REPEATS+1)  count of races that returned 1.
- oresp_stable  out  1  all races agreed.
- opuf_pulse  out  1  drives `arbiter_puf` ipulse.
- opuf_challenge  out  C_LENGTH  drives `arbiter_puf` ichallenge.
- ipuf_response  in  1  `arbiter_puf` oresponse; asynchronous to iclk.

## Operation
- FSM states: IDLE, LOAD, FIRE, SAMPLE, RELAX, DONE.
- **IDLE**
  - oreq_ready=1.
  - On ireq_valid&&oreq_ready: register ireq_challenge into opuf_challenge, clear the ones and repeat counters, go to LOAD.
- **LOAD**: pulse low for C_SETTLE cycles, then go to FIRE.
- **FIRE**: opuf_pulse=1 for C_PULSE_WIDTH cycles, then go to SAMPLE.
- **SAMPLE**
  - Pulse stays high for 2 cycles to cover the 2-flop synchroniser.
  - On the last SAMPLE cycle: ones += synchronised response, repeat += 1. Then go to RELAX.
- **RELAX**
  - Pulse low for C_SETTLE cycles so both delay lines return to 0.
  - Then go to DONE if repeat==C_REPEATS, else go to FIRE.
- **DONE**
  - oresp_valid=1.
  - oresp_bit = (ones > C_REPEATS/2).
  - oresp_stable = (ones==0 || ones==C_REPEATS).
  - Outputs are held stable until iresp_ready, then go to IDLE.
- opuf_challenge is held constant from accept until the next accept; ireq_challenge is ignored while busy.
- oreq_ready=1 only in IDLE. Requests while busy are not accepted and must be held by the requester.
- Counters saturate by construction; oresp_ones never exceeds C_REPEATS.

## Timing
- Reset (irst_n low), asynchronous:
  - state=IDLE.
  - opuf_pulse=0, opuf_challenge=0.
  - oresp_valid=0, oresp_bit=0, oresp_ones=0, oresp_stable=0.
  - Synchroniser flops=0.
  - oreq_ready=1 (decoded from IDLE).
- Accept edge to oresp_valid rising: C_SETTLE + C_REPEATS·(C_PULSE_WIDTH+2+C_SETTLE) cycles. Defaults give 8 + 7·14 = 106.
- Each race: opuf_pulse high for exactly C_PULSE_WIDTH+2 consecutive cycles, low for at least C_SETTLE cycles before the next rising edge.
- DONE handshake cycle → IDLE next cycle. Minimum gap between result consumption and the next accept is 1 cycle; there is no same-cycle accept in DONE.
- Reset mid-operation:
  - opuf_pulse drops immediately.
  - Partial counts are discarded.
  - No oresp_valid is produced for the aborted request.
- All outputs are registered except oreq_ready, which is decoded from state.

## Structure
- `parameters.vh`: C_LENGTH, defaults for C_REPEATS/C_SETTLE/C_PULSE_WIDTH, FSM state encodings as `define constants.
- Sub-module `sync_2ff`: 2-flop synchroniser for ipuf_response, async active-low reset to 0.
- One shared cycle counter, sized for max(C_SETTLE, C_PULSE_WIDTH), used by LOAD/FIRE/SAMPLE/RELAX.
- Top-level pairing with `arbiter_puf` lives in a separate wrapper.

## Test plan
Use a behavioural PUF model whose per-race output is scripted by the bench.
- **Reset:** hold irst_n low → opuf_pulse=0, opuf_challenge=0, oresp_valid=0, oreq_ready=1.
- **Clean response:** challenge 64'hA5A5_A5A5_A5A5_A5A5, model always 1 → oresp_valid exactly 106 cycles after accept; oresp_bit=1, oresp_ones=7, oresp_stable=1; 7 pulses, each high 6 cycles, low ≥8 cycles.
- **Majority vote:**
  - Model returns 1 on races 1, 3, 5 → oresp_bit=0, oresp_ones=3, oresp_stable=0.
  - Model returns 1 on races 0–3 → oresp_bit=1, oresp_ones=4, oresp_stable=0.
- **Backpressure:**
  - Hold iresp_ready=0 for 20 cycles in DONE → all outputs stable, oreq_ready=0, ireq_valid pulses ignored.
  - Then iresp_ready=1 → IDLE next cycle; the next challenge is accepted 1 cycle later.
- **Challenge hold:** toggle ireq_challenge every cycle while busy → opuf_challenge unchanged until the next accept.
- **Reset mid-FIRE:** assert irst_n during a pulse → opuf_pulse=0 within the same cycle. After release, oreq_ready=1, no oresp_valid, and the next request completes normally with oresp_ones counted from 0.
